// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    B_GRN = 3'd2,
    B_YEL = 3'd3,
    NIGHT = 3'd4
  } state_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic state_t next_phase(input state_t s);
    state_t r;
    case (s)
      A_GRN:   r = A_YEL;
      A_YEL:   r = B_GRN;
      B_GRN:   r = B_YEL;
      default: r = A_GRN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_module_if.sv
// Night request in, lamps and countdown digits out.
interface traffic_light_ctrl_module_if;
  logic       Night_Sig;
  logic [2:0] Light_A;
  logic [2:0] Light_B;
  logic [3:0] Ten_Data;
  logic [3:0] One_Data;
  logic       Disp_En;

  modport master (input Night_Sig,
                  output Light_A, Light_B, Ten_Data, One_Data, Disp_En);
  modport slave  (output Night_Sig,
                  input Light_A, Light_B, Ten_Data, One_Data, Disp_En);
endinterface

// File: rtl/traffic_light_ctrl_module_bcd.sv
// Two-digit packed-BCD down-counter with load, decrement and an "at 01" flag.
module bcd_down2_module #(
  parameter logic [7:0] RST_VAL = 8'h25
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic [3:0] o_ten,
  output logic [3:0] o_one,
  output logic       o_is_01
);

  logic [3:0] r_ten;
  logic [3:0] r_one;

  // Load wins over decrement; a zero ones digit borrows from the tens digit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ten <= RST_VAL[7:4];
      r_one <= RST_VAL[3:0];
    end else if (i_load) begin
      r_ten <= i_load_val[7:4];
      r_one <= i_load_val[3:0];
    end else if (i_dec) begin
      if (r_one == '0) begin
        r_one <= 4'd9;
        r_ten <= r_ten - 4'd1;
      end else begin
        r_one <= r_one - 4'd1;
      end
    end
  end

  assign o_ten   = r_ten;
  assign o_one   = r_one;
  assign o_is_01 = (r_ten == 4'd0) && (r_one == 4'd1);

endmodule

// File: rtl/traffic_light_ctrl_module.sv
// Phase sequencer with 1 s tick, BCD countdown and flashing-yellow night override.
module traffic_light_ctrl_module
  import traffic_pkg::*;
#(
  parameter logic [25:0] T1S  = 26'd49_999_999,
  parameter logic [7:0]  T_AG = 8'h25,
  parameter logic [7:0]  T_AY = 8'h05,
  parameter logic [7:0]  T_BG = 8'h20,
  parameter logic [7:0]  T_BY = 8'h05
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  traffic_light_ctrl_module_if.master   bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [25:0] r_count1;
  logic        r_blink;
  logic        w_blink_nxt;
  logic        w_tick;
  logic        w_night_chg;
  logic        w_load;
  logic [7:0]  w_load_val;
  logic        w_dec;
  logic        w_is_01;
  logic [3:0]  w_ten;
  logic [3:0]  w_one;
  logic [2:0]  r_light_a;
  logic [2:0]  r_light_b;
  logic        r_disp_en;
  logic [2:0]  w_light_a_nxt;
  logic [2:0]  w_light_b_nxt;

  assign w_tick = (r_count1 == T1S);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= A_GRN;
      r_count1 <= '0;
      r_blink  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_blink  <= w_blink_nxt;
      r_count1 <= (w_night_chg || w_tick) ? '0 : r_count1 + 26'd1;
    end
  end

  // Night request is evaluated before the tick so it wins a same-cycle collision.
  always_comb begin
    w_state_nxt = r_state;
    w_blink_nxt = r_blink;
    w_night_chg = 1'b0;
    w_load      = 1'b0;
    w_load_val  = T_AG;
    w_dec       = 1'b0;
    if (r_state != NIGHT && bus.Night_Sig) begin
      w_state_nxt = NIGHT;
      w_blink_nxt = 1'b1;
      w_night_chg = 1'b1;
      w_load      = 1'b1;
      w_load_val  = '0;
    end else if (r_state == NIGHT && !bus.Night_Sig) begin
      w_state_nxt = A_GRN;
      w_blink_nxt = 1'b0;
      w_night_chg = 1'b1;
      w_load      = 1'b1;
      w_load_val  = T_AG;
    end else if (w_tick) begin
      if (r_state == NIGHT) begin
        w_blink_nxt = ~r_blink;
      end else if (w_is_01) begin
        w_state_nxt = next_phase(r_state);
        w_load      = 1'b1;
        case (w_state_nxt)
          A_YEL:   w_load_val = T_AY;
          B_GRN:   w_load_val = T_BG;
          B_YEL:   w_load_val = T_BY;
          default: w_load_val = T_AG;
        endcase
      end else begin
        w_dec = 1'b1;
      end
    end
  end

  // Lamps are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    w_light_a_nxt = LAMP_OFF;
    w_light_b_nxt = LAMP_OFF;
    case (w_state_nxt)
      A_GRN: begin w_light_a_nxt = LAMP_G; w_light_b_nxt = LAMP_R; end
      A_YEL: begin w_light_a_nxt = LAMP_Y; w_light_b_nxt = LAMP_R; end
      B_GRN: begin w_light_a_nxt = LAMP_R; w_light_b_nxt = LAMP_G; end
      B_YEL: begin w_light_a_nxt = LAMP_R; w_light_b_nxt = LAMP_Y; end
      default: begin
        w_light_a_nxt = w_blink_nxt ? LAMP_Y : LAMP_OFF;
        w_light_b_nxt = w_blink_nxt ? LAMP_Y : LAMP_OFF;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_light_a <= LAMP_G;
      r_light_b <= LAMP_R;
      r_disp_en <= 1'b1;
    end else begin
      r_light_a <= w_light_a_nxt;
      r_light_b <= w_light_b_nxt;
      r_disp_en <= (w_state_nxt != NIGHT);
    end
  end

  bcd_down2_module #(.RST_VAL(T_AG)) u_bcd (
    .i_clk      (CLK),
    .i_rst_n    (RSTn),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_ten      (w_ten),
    .o_one      (w_one),
    .o_is_01    (w_is_01)
  );

  assign bus.Light_A  = r_light_a;
  assign bus.Light_B  = r_light_b;
  assign bus.Ten_Data = w_ten;
  assign bus.One_Data = w_one;
  assign bus.Disp_En  = r_disp_en;

endmodule
